// File: rtl/sseg_pkg.sv
// Shared constants and helpers for the seven-segment score counter.
package sseg_pkg;

   localparam int unsigned SSEG_NUM_W   = 14;
   localparam int unsigned SSEG_DIGITS  = 4;
   localparam int unsigned SSEG_MAX_DEC = 9999;

   // Value at which each non-rightmost digit becomes significant.
   localparam int unsigned SSEG_THR_10   = 10;
   localparam int unsigned SSEG_THR_100  = 100;
   localparam int unsigned SSEG_THR_1000 = 1000;

   typedef logic [SSEG_NUM_W-1:0]  sseg_num_t;
   typedef logic [SSEG_DIGITS-1:0] sseg_mask_t;

   // Clamp a raw value to an upper bound.
   function automatic sseg_num_t sseg_clamp(input sseg_num_t val, input sseg_num_t max_val);
      return (val > max_val) ? max_val : val;
   endfunction

endpackage

// File: rtl/sseg_blank_gen.sv
// Leading-zero blanking: enables only the digits that carry significance.
module sseg_blank_gen
   import sseg_pkg::*;
(
   input  sseg_num_t  value_i,
   output sseg_mask_t dig_en_o
);

   // Rightmost digit always lit so zero still shows as "0".
   always_comb begin
      dig_en_o    = '0;
      dig_en_o[0] = 1'b1;
      dig_en_o[1] = (value_i >= SSEG_NUM_W'(SSEG_THR_10));
      dig_en_o[2] = (value_i >= SSEG_NUM_W'(SSEG_THR_100));
      dig_en_o[3] = (value_i >= SSEG_NUM_W'(SSEG_THR_1000));
   end

endmodule

// File: rtl/sseg_score_counter.sv
// Saturating score counter feeding a 4-digit seven-segment controller.
// Optional feature: define SSEG_SCORE_BLINK_EN to blink the display while saturated.
module sseg_score_counter
   import sseg_pkg::*;
#(
   parameter int unsigned MAX       = 9999,
   parameter int unsigned BLINK_DIV = 25000000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load_i,
   input  logic [13:0] load_val_i,
   input  logic        inc_i,
   input  logic        dec_i,
   input  logic [3:0]  step_i,
   input  logic        dp_we_i,
   input  logic [3:0]  dp_sel_i,
   input  logic        clr_sat_i,
   output logic [13:0] num_o,
   output logic [3:0]  dig_en_o,
   output logic [3:0]  dp_en_o,
   output logic        sat_o
);

   localparam sseg_num_t               MaxV  = SSEG_NUM_W'(MAX);
   localparam logic [SSEG_NUM_W:0]     MaxW  = (SSEG_NUM_W + 1)'(MAX);

   if (MAX < 1 || MAX > SSEG_MAX_DEC || BLINK_DIV < 2) begin : g_param_check
      $error("sseg_score_counter: MAX or BLINK_DIV out of range");
   end

   sseg_num_t             num_q, num_d;
   logic                  sat_q, sat_d;
   sseg_mask_t            dp_q, dp_d;
   sseg_mask_t            dig_en_q, dig_en_d;
   sseg_mask_t            blank_en;
   logic                  sat_set;
   logic [SSEG_NUM_W:0]   sum;
   logic signed [15:0]    diff;

   assign sum  = {1'b0, num_q} + {{(SSEG_NUM_W - 3){1'b0}}, step_i};
   assign diff = signed'({2'b00, num_q}) - signed'({12'd0, step_i});

   // Next value of num and the saturation event; load has priority over inc/dec.
   always_comb begin
      num_d   = num_q;
      sat_set = 1'b0;
      if (load_i) begin
         num_d = sseg_clamp(load_val_i, MaxV);
      end else if (inc_i && !dec_i) begin
         if (sum > MaxW) begin
            num_d   = MaxV;
            sat_set = 1'b1;
         end else begin
            num_d = sum[SSEG_NUM_W-1:0];
         end
      end else if (dec_i && !inc_i) begin
         if (diff < 0) begin
            num_d   = '0;
            sat_set = 1'b1;
         end else begin
            num_d = diff[SSEG_NUM_W-1:0];
         end
      end
   end

   // Sticky flag: a set on the same edge as a clear wins.
   always_comb begin
      sat_d = sat_q;
      if (sat_set) begin
         sat_d = 1'b1;
      end else if (clr_sat_i || load_i) begin
         sat_d = 1'b0;
      end
      dp_d = dp_we_i ? dp_sel_i : dp_q;
   end

   // Blanking is computed from num_d so the registered num and dig_en always agree.
   sseg_blank_gen u_blank_gen (
      .value_i  (num_d),
      .dig_en_o (blank_en)
   );

`ifdef SSEG_SCORE_BLINK_EN
   localparam int unsigned CntW = $clog2(BLINK_DIV);

   logic [CntW-1:0] blink_cnt_q, blink_cnt_d;
   logic            phase_on_q, phase_on_d;

   // Blink timebase restarts (phase on) whenever sat is, or is about to become, clear,
   // and on the edge that first sets sat so every period is a full BLINK_DIV cycles.
   always_comb begin
      blink_cnt_d = blink_cnt_q;
      phase_on_d  = phase_on_q;
      if (!sat_d || !sat_q) begin
         blink_cnt_d = '0;
         phase_on_d  = 1'b1;
      end else if (blink_cnt_q == CntW'(BLINK_DIV - 1)) begin
         blink_cnt_d = '0;
         phase_on_d  = ~phase_on_q;
      end else begin
         blink_cnt_d = blink_cnt_q + 1'b1;
      end
      dig_en_d = phase_on_d ? blank_en : '0;
   end

   // Blink timebase state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blink_cnt_q <= '0;
         phase_on_q  <= 1'b1;
      end else begin
         blink_cnt_q <= blink_cnt_d;
         phase_on_q  <= phase_on_d;
      end
   end
`else
   // No blinking: digit enables follow the blanking rule only.
   always_comb begin
      dig_en_d = blank_en;
   end
`endif

   // Registered value, flags and display enables.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         num_q    <= '0;
         sat_q    <= 1'b0;
         dp_q     <= '0;
         dig_en_q <= 4'b0001;
      end else begin
         num_q    <= num_d;
         sat_q    <= sat_d;
         dp_q     <= dp_d;
         dig_en_q <= dig_en_d;
      end
   end

   assign num_o    = num_q;
   assign dig_en_o = dig_en_q;
   assign dp_en_o  = dp_q;
   assign sat_o    = sat_q;

endmodule

// File: tb/tb_sseg_score_counter.sv
// Directed, table-driven bench for sseg_score_counter.
module tb_sseg_score_counter;

   logic        clk;
   logic        rst_n;
   logic        load_i;
   logic [13:0] load_val_i;
   logic        inc_i;
   logic        dec_i;
   logic [3:0]  step_i;
   logic        dp_we_i;
   logic [3:0]  dp_sel_i;
   logic        clr_sat_i;
   logic [13:0] num_o;
   logic [3:0]  dig_en_o;
   logic [3:0]  dp_en_o;
   logic        sat_o;

   int n_pass;
   int n_tot;

   sseg_score_counter #(
      .MAX       (9999),
      .BLINK_DIV (4)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (load_i),
      .load_val_i (load_val_i),
      .inc_i      (inc_i),
      .dec_i      (dec_i),
      .step_i     (step_i),
      .dp_we_i    (dp_we_i),
      .dp_sel_i   (dp_sel_i),
      .clr_sat_i  (clr_sat_i),
      .num_o      (num_o),
      .dig_en_o   (dig_en_o),
      .dp_en_o    (dp_en_o),
      .sat_o      (sat_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        load;
      logic [13:0] lv;
      logic        inc;
      logic        dec;
      logic [3:0]  step;
      logic        dpwe;
      logic [3:0]  dps;
      logic        clr;
      logic [13:0] e_num;
      logic [3:0]  e_dig;
      logic [3:0]  e_dp;
      logic        e_sat;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input int act, input int exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic chk_all(input string name, input int en, input int ed, input int edp,
                          input int es);
      chk({name, ".num"}, int'(num_o), en);
      chk({name, ".dig_en"}, int'(dig_en_o), ed);
      chk({name, ".dp_en"}, int'(dp_en_o), edp);
      chk({name, ".sat"}, int'(sat_o), es);
   endtask

   task automatic idle();
      load_i = 0; load_val_i = 0; inc_i = 0; dec_i = 0; step_i = 0;
      dp_we_i = 0; dp_sel_i = 0; clr_sat_i = 0;
   endtask

   function automatic vec_t mk(string n, logic ld, int lv, logic in, logic de, int st,
                               logic we, int ds, logic cl, int en, int ed, int edp, logic es);
      vec_t v;
      v.name = n; v.load = ld; v.lv = 14'(lv); v.inc = in; v.dec = de; v.step = 4'(st);
      v.dpwe = we; v.dps = 4'(ds); v.clr = cl; v.e_num = 14'(en); v.e_dig = 4'(ed);
      v.e_dp = 4'(edp); v.e_sat = es;
      return v;
   endfunction

   initial begin
      n_pass = 0;
      n_tot  = 0;
      idle();
      rst_n = 1'b0;

      //            name          ld  lv     inc dec st  we  dps  clr  num   dig   dp    sat
      vecs.push_back(mk("inc9a",   0, 0,     1,  0,  9,  0,  0,   0,   9,    'b0001, 0, 0));
      vecs.push_back(mk("inc9b",   0, 0,     1,  0,  9,  0,  0,   0,   18,   'b0011, 0, 0));
      vecs.push_back(mk("ld9995",  1, 9995,  0,  0,  0,  0,  0,   0,   9995, 'b1111, 0, 0));
      vecs.push_back(mk("incsat",  0, 0,     1,  0,  7,  0,  0,   0,   9999, 'b1111, 0, 1));
      vecs.push_back(mk("clrsat",  0, 0,     0,  0,  0,  0,  0,   1,   9999, 'b1111, 0, 0));
      vecs.push_back(mk("ld3",     1, 3,     0,  0,  0,  0,  0,   0,   3,    'b0001, 0, 0));
      vecs.push_back(mk("decsat",  0, 0,     0,  1,  5,  0,  0,   0,   0,    'b0001, 0, 1));
      vecs.push_back(mk("ld20",    1, 20,    0,  0,  0,  0,  0,   0,   20,   'b0011, 0, 0));
      vecs.push_back(mk("incdec",  0, 0,     1,  1,  4,  0,  0,   0,   20,   'b0011, 0, 0));
      vecs.push_back(mk("ld12000", 1, 12000, 0,  0,  0,  0,  0,   0,   9999, 'b1111, 0, 0));
      vecs.push_back(mk("ld999",   1, 999,   0,  0,  0,  0,  0,   0,   999,  'b0111, 0, 0));
      vecs.push_back(mk("dpwe",    0, 0,     0,  0,  0,  1,  4,   0,   999,  'b0111, 4, 0));
      vecs.push_back(mk("dec0",    0, 0,     0,  1,  0,  0,  0,   0,   999,  'b0111, 4, 0));
      vecs.push_back(mk("inc15",   0, 0,     1,  0,  15, 0,  0,   0,   1014, 'b1111, 4, 0));
      vecs.push_back(mk("ld9999",  1, 9999,  0,  0,  0,  0,  0,   0,   9999, 'b1111, 4, 0));
      vecs.push_back(mk("inc0max", 0, 0,     1,  0,  0,  0,  0,   0,   9999, 'b1111, 4, 0));
      vecs.push_back(mk("setwins", 0, 0,     1,  0,  1,  0,  0,   1,   9999, 'b1111, 4, 1));
      vecs.push_back(mk("dphold",  0, 0,     0,  0,  0,  0,  10,  0,   9999, 'b1111, 4, 1));
      vecs.push_back(mk("decclr",  0, 0,     0,  1,  15, 0,  0,   1,   9984, 'b1111, 4, 0));
      vecs.push_back(mk("ld10",    1, 10,    0,  0,  0,  0,  0,   0,   10,   'b0011, 4, 0));
      vecs.push_back(mk("dec1",    0, 0,     0,  1,  1,  0,  0,   0,   9,    'b0001, 4, 0));

      #12;
      chk_all("reset", 0, 'b0001, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         load_i = vecs[i].load; load_val_i = vecs[i].lv; inc_i = vecs[i].inc;
         dec_i = vecs[i].dec; step_i = vecs[i].step; dp_we_i = vecs[i].dpwe;
         dp_sel_i = vecs[i].dps; clr_sat_i = vecs[i].clr;
         @(posedge clk);
         #1;
         chk_all(vecs[i].name, int'(vecs[i].e_num), int'(vecs[i].e_dig), int'(vecs[i].e_dp),
                 int'(vecs[i].e_sat));
         idle();
      end

      // Async reset mid-inc: outputs clear without a clock edge, then resume cleanly.
      @(negedge clk);
      load_i = 1; load_val_i = 14'd500; dp_we_i = 1; dp_sel_i = 4'b0110;
      @(posedge clk);
      #1;
      chk_all("ld500", 500, 'b0111, 'b0110, 0);
      idle();
      inc_i = 1; step_i = 4'd5;
      #2;
      rst_n = 1'b0;
      #1;
      chk_all("async_rst", 0, 'b0001, 0, 0);
      @(posedge clk);
      #1;
      chk_all("rst_held", 0, 'b0001, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst.num", int'(num_o), 5);
      idle();
      @(negedge clk);
      dp_we_i = 1; dp_sel_i = 4'b0100;
      @(posedge clk);
      #1;
      chk("dp0100", int'(dp_en_o), 'b0100);
      idle();

`ifdef SSEG_SCORE_BLINK_EN
      // Saturate, then expect 4 cycles on / 4 cycles off with BLINK_DIV=4.
      @(negedge clk);
      load_i = 1; load_val_i = 14'd9998;
      @(negedge clk);
      idle();
      inc_i = 1; step_i = 4'd3;
      for (int k = 0; k < 16; k++) begin
         @(posedge clk);
         #1;
         idle();
         chk($sformatf("blink%0d", k), int'(dig_en_o), ((k % 8) < 4) ? 'b1111 : 'b0000);
      end
      @(negedge clk);
      clr_sat_i = 1;
      @(posedge clk);
      #1;
      idle();
      chk("blink_clr", int'(dig_en_o), 'b1111);
      for (int k = 0; k < 6; k++) begin
         @(posedge clk);
         #1;
         chk($sformatf("steady%0d", k), int'(dig_en_o), 'b1111);
      end
`endif

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule

// File: doc/sseg_score_counter.md
SSEG_SCORE_COUNTER -- requirements
Module: sseg_score_counter

Interface
REQ-001 Parameter MAX, default 9999, meaning: upper saturation bound of the value; legal range 1..9999.
REQ-002 Parameter BLINK_DIV, default 25000000, meaning: clk cycles per blink half-period; legal range >=2.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous and active-low.
REQ-005 load  input  1  when high, load_val is loaded on this edge.
REQ-006 load_val  input  14  value to load; values above MAX are clamped to MAX.
REQ-007 inc  input  1  add step to the value on this edge.
REQ-008 dec  input  1  subtract step from the value on this edge.
REQ-009 step  input  4  increment/decrement amount, 0..15.
REQ-010 dp_we  input  1  write dp_sel into the decimal-point register on this edge.
REQ-011 dp_sel  input  4  decimal-point mask, bit 0 = rightmost digit.
REQ-012 clr_sat  input  1  clears the sticky saturation flag.
REQ-013 num  output  14  registered display value, 0..MAX; feeds the seven-segment controller num input.
REQ-014 dig_en  output  4  registered digit enables with leading zeros blanked; bit 0 = rightmost digit.
REQ-015 dp_en  output  4  registered decimal-point enables.
REQ-016 sat  output  1  sticky flag; set when an inc or dec is clamped.

Function
REQ-017 Priority on each edge: load, then inc/dec; inc and dec high together SHALL leave num unchanged.
REQ-018 inc SHALL set num to min(num+step, MAX), computed at 15-bit width with no wrap.
REQ-019 dec SHALL set num to max(num-step, 0), computed signed with no wrap below 0.
REQ-020 sat SHALL set on the edge where an inc result exceeds MAX or a dec result falls below 0; step=0 never sets sat.
REQ-021 sat SHALL clear on clr_sat or load; if a set condition and a clear occur on the same edge, set wins.
REQ-022 Latency: num, dig_en and sat SHALL reflect an inc/dec/load one cycle after the sampling edge; dig_en SHALL be derived from the next value of num so that num and dig_en never disagree.
REQ-023 Blanking: dig_en[0]=1 always; dig_en[1]=(num>=10); dig_en[2]=(num>=100); dig_en[3]=(num>=1000).
REQ-024 dp_en SHALL update to dp_sel one cycle after dp_we and hold otherwise; dp_en is independent of blanking.

Reset
REQ-025 rst_n low SHALL asynchronously force num=0, dig_en=4'b0001, dp_en=4'b0000, sat=0 and the blink counter/phase to 0/on.
REQ-026 Reset asserted mid-operation SHALL discard any in-flight load/inc/dec; the first edge after deassertion SHALL process inputs normally.

Configuration
REQ-027 Macro SSEG_SCORE_BLINK_EN: when defined, while sat=1 a counter SHALL toggle a blink phase every BLINK_DIV cycles, forcing dig_en=4'b0000 during the off phase.
REQ-028 When the blink logic is defined, the counter and phase SHALL reset to 0/on whenever sat is 0.
REQ-029 When SSEG_SCORE_BLINK_EN is undefined, the blink counter SHALL be absent, dig_en SHALL follow REQ-023 only, and sat behaviour SHALL be unchanged.

Structure
REQ-030 Shared package sseg_pkg SHALL hold SSEG_NUM_W=14, SSEG_DIGITS=4, SSEG_MAX_DEC=9999 and the digit thresholds 10/100/1000.
REQ-031 The leading-zero blanking logic SHALL be a sub-module sseg_blank_gen (14-bit value in, 4-bit enable out, combinational).
REQ-032 Total RTL SHALL fit in 120-400 lines across both modules.

Verification
REQ-033 Reset, then inc with step=9 twice -> num=9 then 18; dig_en=0001 then 0011; sat=0.
REQ-034 load with load_val=9995, then inc with step=7 -> num=9999 and sat=1; clr_sat -> sat=0 and num stays 9999.
REQ-035 num=3, dec with step=5 -> num=0, dig_en=0001, sat=1; inc and dec together with step=4 -> num unchanged.
REQ-036 load with load_val=12000 -> num=9999, dig_en=1111; load with 999 -> dig_en=0111, sat=0.
REQ-037 With SSEG_SCORE_BLINK_EN and BLINK_DIV=4, saturate -> dig_en alternates on/off every 4 cycles; clr_sat -> steady and phase on.
REQ-038 Assert rst_n mid-inc with num=500 -> outputs take reset values immediately without waiting for clk; dp_we with dp_sel=0100 -> dp_en=0100 next cycle.
